// File: rtl/divider_pkg.sv
// Shared constants and types for the programmable clock-enable divider.
package divider_pkg;
  localparam int WIDTH_DEF       = 8;
  localparam int DEFAULT_DIV_DEF = 6;
  localparam int MIN_DIV         = 2;

  typedef logic [WIDTH_DEF-1:0] div_t;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/divider_param_if.sv
// Ratio configuration channel: request from control logic, ready/error back.
interface divider_param_if
  import divider_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int WIDTH  = WIDTH_DEF
);
  localparam int CH_W = ch_w(NUM_CH);

  logic             cfg_valid;
  logic [CH_W-1:0]  cfg_ch;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (output cfg_valid, cfg_ch, cfg_div, input cfg_ready, cfg_err);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, output cfg_ready, cfg_err);
endinterface

// File: rtl/divider_chan.sv
// One divider channel: counter, active/pending ratio, registered flag and level outputs.
module divider_chan
  import divider_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_ld,
  input  logic [WIDTH-1:0] i_ld_val,
  output logic             o_pend_vld,
  output logic             o_clk_flag,
  output logic             o_clk_out
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_cnt, r_ratio, r_pend;
  logic             r_pend_vld, r_flag, r_out;
  logic             w_wrap, w_apply;
  logic [WIDTH-1:0] w_cnt_nxt, w_ratio_nxt;

  // A pending ratio only lands on a period boundary, or at once while idle.
  always_comb begin
    w_wrap      = i_en && (r_cnt == r_ratio - ONE);
    w_apply     = r_pend_vld && (w_wrap || !i_en);
    w_cnt_nxt   = (!i_en || w_wrap) ? '0 : r_cnt + ONE;
    w_ratio_nxt = w_apply ? r_pend : r_ratio;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt      <= '0;
      r_ratio    <= WIDTH'(DEFAULT_DIV);
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_flag     <= 1'b0;
      r_out      <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_ratio <= w_ratio_nxt;
      if (w_apply) begin
        r_pend_vld <= 1'b0;
      end else if (i_ld) begin
        r_pend     <= i_ld_val;
        r_pend_vld <= 1'b1;
      end
      // Decode from next-state values so outputs line up with the counter.
      r_flag <= i_en && (w_cnt_nxt == w_ratio_nxt - ONE);
      r_out  <= i_en && (w_cnt_nxt < (w_ratio_nxt >> 1));
    end
  end

  assign o_pend_vld = r_pend_vld;
  assign o_clk_flag = r_flag;
  assign o_clk_out  = r_out;
endmodule

// File: rtl/divider_param.sv
// Multi-channel runtime-programmable clock-enable generator with config decode.
module divider_param
  import divider_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int WIDTH       = WIDTH_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [NUM_CH-1:0] en,
  divider_param_if.slave    cfg,
  output logic [NUM_CH-1:0] clk_flag,
  output logic [NUM_CH-1:0] clk_out
);
  localparam int CH_W = ch_w(NUM_CH);

  logic [NUM_CH-1:0] w_sel, w_pend, w_ld;
  logic              w_ready, w_acc, w_legal;
  logic              r_err;

  // An out-of-range channel selects nothing, so it reads as ready and is flagged illegal.
  assign w_ready = ~|(w_sel & w_pend);
  assign w_acc   = cfg.cfg_valid && w_ready;
  assign w_legal = (|w_sel) && (cfg.cfg_div >= WIDTH'(MIN_DIV));

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_sel[g] = (cfg.cfg_ch == CH_W'(g));
    assign w_ld[g]  = w_acc && w_legal && w_sel[g];

    divider_chan #(.WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV)) u_chan (
      .i_clk      (sys_clk),
      .i_rst      (sys_rst),
      .i_en       (en[g]),
      .i_ld       (w_ld[g]),
      .i_ld_val   (cfg.cfg_div),
      .o_pend_vld (w_pend[g]),
      .o_clk_flag (clk_flag[g]),
      .o_clk_out  (clk_out[g])
    );
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_err <= 1'b0;
    else         r_err <= w_acc && !w_legal;
  end

  assign cfg.cfg_ready = w_ready;
  assign cfg.cfg_err   = r_err;
endmodule
